cbus_master_if: RTL and testbench
=================================

# cbus_master_if

Initiator end of the cbus configuration bus. Accepts single read/write requests from a local host (CPU bridge, debug port or sequencer), drives the cbus request signals into a `cbus_select_if`-style slave, waits for the accept/response, and returns write completion or read data to the host. One outstanding transaction; optional timeout abort.

## Interface

- `DW`, 32, data width
- `AW`, 16, cbus address width
- `TIM_WID`, 8, timeout counter width
- `TIMEOUT_CYC`, 255, REQ cycles without ack before abort; legal range 1 to 2^TIM_WID-1
- `clk`  in  1  system clock
- `sreset`  in  1  synchronous reset, active-high
- `host_req_valid`  in  1  host request present
- `host_req_ready`  out  1  block can accept a request
- `host_wr_rd_n`  in  1  1 = write, 0 = read
- `host_addr`  in  AW  target address; upper bits select the unit
- `host_wdata`  in  DW  write data
- `host_rsp_valid`  out  1  one-cycle completion pulse
- `host_rsp_rdata`  out  DW  read data; 0 for writes
- `host_rsp_err`  out  1  transaction aborted on timeout
- `cbus_mst_address`  out  AW  to slave `cbus_slv_address`
- `cbus_mst_cfg_req`  out  1  to slave `cbus_slv_cfg_req`
- `cbus_mst_cmd`  out  1  to slave `cbus_slv_cmd`
- `cbus_mst_wdata`  out  DW  to slave `cbus_slv_wdata`
- `cbus_mst_waccept`  in  1  from slave, write accept
- `cbus_mst_rresp`  in  1  from slave, read response
- `cbus_mst_rdatap`  in  DW  from slave; valid the cycle after `rresp`

## Operation

- States: IDLE, SETUP, REQ, CAPT, RESP.
- IDLE: `host_req_ready`=1. When `host_req_valid`=1, register addr, cmd and wdata onto the cbus outputs and go to SETUP.
- SETUP: address, cmd and wdata are stable and `cfg_req`=0. This gives the slave one cycle to register the unit select. Next state is REQ.
- REQ: `cfg_req`=1. The ack is `waccept` for writes and `rresp` for reads. The other signal is ignored. On ack, go to CAPT. `cfg_req` is registered low at the same edge.
- CAPT: `cfg_req`=0. For reads, capture `cbus_mst_rdatap` at the end of this cycle. For writes, capture nothing and set rdata to 0. Next state is RESP.
- RESP: `host_rsp_valid`=1 for exactly one cycle, then IDLE. This also guarantees one idle bus cycle so the slave's ack can fall before the next request.
- The cbus address, cmd and wdata outputs hold their values from acceptance until the next acceptance.
- Ack seen outside REQ is ignored.
- Reset, including mid-transaction: go to IDLE immediately. The pending transaction is dropped and no response is issued.

## Timing

- Reset values: every output is 0, including `host_req_ready` while `sreset`=1. `host_req_ready`=1 from the first cycle after reset deasserts.
- Request accepted at cycle 0:
  - SETUP in cycle 1.
  - `cfg_req` high from cycle 2.
  - Ack at cycle n (n≥2) gives CAPT at n+1, `host_rsp_valid` at n+2, and `host_req_ready` at n+3.
- Minimum transaction: 5 cycles, accept to next ready.
- Back-to-back request throughput: one per n+3 cycles.
- Timeout counter:
  - Width `TIM_WID`, cleared on entry to REQ, incremented each REQ cycle without ack.
  - When the count reaches `TIMEOUT_CYC` without ack, go to RESP with `host_rsp_err`=1 and rdata = `CBUS_ERR_RDATA`. `cfg_req` drops at the same edge.
  - If ack and expiry occur in the same cycle, ack wins.
  - The counter saturates and never wraps.

## Configuration

- `CBUS_MST_TIMEOUT_EN` defined: timeout counter and abort path present, as described above.
- Not defined:
  - No counter and no abort path.
  - REQ waits indefinitely.
  - `host_rsp_err` is tied to 0.
  - `TIM_WID` and `TIMEOUT_CYC` are unused.

## Structure

- Shared package `cbus_pkg`:
  - state encoding constants (IDLE=3'b000, SETUP=3'b001, REQ=3'b101, CAPT=3'b111, RESP=3'b110)
  - `CBUS_ERR_RDATA` = 32'hDEAD_C0DE
  - default `DW`/`AW`
- Natural sub-module: `cbus_mst_tmo_cnt` holds the saturating counter and expiry flag. It is instantiated only under `CBUS_MST_TIMEOUT_EN`.

## Test plan

- Write: addr 16'h2004, wdata 32'h1234_5678, slave acks 3 cycles after `cfg_req` rises.
  - Cbus outputs hold 16'h2004 / 32'h1234_5678 / cmd=1.
  - `cfg_req` is high for exactly 4 cycles.
  - `host_rsp_valid` is high for 1 cycle, with err=0 and rdata=0.
- Read: addr 16'hE010, slave `rresp` in the first REQ cycle, `rdatap`=32'hCAFE_F00D the next cycle.
  - `host_rsp_rdata`=32'hCAFE_F00D, `host_rsp_valid` 2 cycles after `rresp`.
- Back-to-back: `host_req_valid` held high for two requests.
  - Second accept occurs exactly n+3 cycles after the first.
  - `cfg_req` is low for ≥2 cycles between the two requests.
- Timeout (`TIMEOUT_CYC`=4, macro defined), no ack:
  - `cfg_req` is high for 4 cycles.
  - Response has err=1 and rdata=32'hDEAD_C0DE.
- Same (`TIMEOUT_CYC`=4), with ack arriving on the expiry cycle:
  - Normal completion with err=0.
- `sreset` asserted during REQ:
  - Next cycle all outputs are 0 and no `host_rsp_valid` occurs.
  - A new request after reset completes normally.

Source files
------------

// File: rtl/cbus_pkg.sv
// Shared definitions for the cbus master: FSM state encoding, error read data,
// default bus widths and the ack-select helper.
package cbus_pkg;

  localparam int CBUS_DW = 32;
  localparam int CBUS_AW = 16;

  localparam logic [31:0] CBUS_ERR_RDATA = 32'hDEAD_C0DE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SETUP = 3'b001,
    ST_REQ   = 3'b101,
    ST_CAPT  = 3'b111,
    ST_RESP  = 3'b110
  } cbus_state_e;

  // Writes complete on waccept, reads on rresp; the other strobe is ignored.
  function automatic logic cbus_ack(input logic cmd, input logic waccept, input logic rresp);
    return cmd ? waccept : rresp;
  endfunction

endpackage

// File: rtl/cbus_master_if_if.sv
// Host-side request/response and cbus-side signals of the cbus master.
// master = the cbus_master_if block, slave = host plus cbus slave environment.
interface cbus_master_if_if #(
  parameter int DW = cbus_pkg::CBUS_DW,
  parameter int AW = cbus_pkg::CBUS_AW
);
  logic          host_req_valid;
  logic          host_req_ready;
  logic          host_wr_rd_n;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rsp_valid;
  logic [DW-1:0] host_rsp_rdata;
  logic          host_rsp_err;
  logic [AW-1:0] cbus_mst_address;
  logic          cbus_mst_cfg_req;
  logic          cbus_mst_cmd;
  logic [DW-1:0] cbus_mst_wdata;
  logic          cbus_mst_waccept;
  logic          cbus_mst_rresp;
  logic [DW-1:0] cbus_mst_rdatap;

  modport master (
    input  host_req_valid, host_wr_rd_n, host_addr, host_wdata,
           cbus_mst_waccept, cbus_mst_rresp, cbus_mst_rdatap,
    output host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
           cbus_mst_address, cbus_mst_cfg_req, cbus_mst_cmd, cbus_mst_wdata
  );

  modport slave (
    output host_req_valid, host_wr_rd_n, host_addr, host_wdata,
           cbus_mst_waccept, cbus_mst_rresp, cbus_mst_rdatap,
    input  host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
           cbus_mst_address, cbus_mst_cfg_req, cbus_mst_cmd, cbus_mst_wdata
  );
endinterface

// File: rtl/cbus_mst_tmo_cnt.sv
// Saturating REQ-phase cycle counter with expiry flag for the cbus master
// timeout abort (used only when CBUS_MST_TIMEOUT_EN is defined).
module cbus_mst_tmo_cnt #(
  parameter int TIM_WID     = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic sreset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);
  logic [TIM_WID-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (sreset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {TIM_WID{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One more un-acked REQ cycle brings the count to TIMEOUT_CYC.
  assign o_expire = (r_cnt >= TIM_WID'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/cbus_master_if.sv
// cbus initiator: one outstanding host read/write driven onto the cbus.
// Optional timeout abort enabled by defining CBUS_MST_TIMEOUT_EN.
module cbus_master_if
  import cbus_pkg::*;
#(
  parameter int DW          = CBUS_DW,
  parameter int AW          = CBUS_AW,
  parameter int TIM_WID     = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             sreset,
  cbus_master_if_if.master bus
);
  cbus_state_e   r_state;
  logic          r_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic [AW-1:0] r_addr;
  logic          r_cmd;
  logic [DW-1:0] r_wdata;
  logic          r_cfg_req;
  logic          w_ack;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << TIM_WID) - 1) begin : g_bad_timeout
    $error("cbus_master_if: TIMEOUT_CYC outside 1 .. 2**TIM_WID-1");
  end

  assign w_ack = cbus_ack(r_cmd, bus.cbus_mst_waccept, bus.cbus_mst_rresp);

`ifdef CBUS_MST_TIMEOUT_EN
  logic w_expire;
  logic r_rsp_err;

  cbus_mst_tmo_cnt #(
    .TIM_WID    (TIM_WID),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk     (clk),
    .sreset  (sreset),
    .i_clr   (r_state == ST_SETUP),
    .i_inc   ((r_state == ST_REQ) && !w_ack),
    .o_expire(w_expire)
  );
`endif

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_cmd       <= 1'b0;
      r_wdata     <= '0;
      r_cfg_req   <= 1'b0;
`ifdef CBUS_MST_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // ready is registered, so the first post-reset IDLE cycle only raises it
          if (r_ready && bus.host_req_valid) begin
            r_addr  <= bus.host_addr;
            r_cmd   <= bus.host_wr_rd_n;
            r_wdata <= bus.host_wdata;
            r_ready <= 1'b0;
            r_state <= ST_SETUP;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_cfg_req <= 1'b1;
          r_state   <= ST_REQ;
        end
        ST_REQ: begin
          if (w_ack) begin
            r_cfg_req <= 1'b0;
            r_state   <= ST_CAPT;
          end
`ifdef CBUS_MST_TIMEOUT_EN
          else if (w_expire) begin
            r_cfg_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= DW'(CBUS_ERR_RDATA);
            r_state     <= ST_RESP;
          end
`endif
        end
        ST_CAPT: begin
          r_rsp_rdata <= r_cmd ? '0 : bus.cbus_mst_rdatap;
          r_rsp_valid <= 1'b1;
`ifdef CBUS_MST_TIMEOUT_EN
          r_rsp_err   <= 1'b0;
`endif
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.host_req_ready   = r_ready;
  assign bus.host_rsp_valid   = r_rsp_valid;
  assign bus.host_rsp_rdata   = r_rsp_rdata;
  assign bus.cbus_mst_address = r_addr;
  assign bus.cbus_mst_cfg_req = r_cfg_req;
  assign bus.cbus_mst_cmd     = r_cmd;
  assign bus.cbus_mst_wdata   = r_wdata;
`ifdef CBUS_MST_TIMEOUT_EN
  assign bus.host_rsp_err     = r_rsp_err;
`else
  assign bus.host_rsp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_cbus_master_if.sv
// Directed, table-driven bench for cbus_master_if plus hand-written
// back-to-back and reset-during-REQ sequences.
module tb_cbus_master_if;

  localparam int DW = 32;
  localparam int AW = 16;

  logic clk;
  logic sreset;
  int   n_vec;
  int   n_err;

  cbus_master_if_if #(.DW(DW), .AW(AW)) bus ();

  cbus_master_if #(
    .DW         (DW),
    .AW         (AW),
    .TIM_WID    (8),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk   (clk),
    .sreset(sreset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;   // ack at cycle 2+ack_dly after accept, -1 = never
    logic          early;     // strobe both acks during SETUP
    logic          noise;     // strobe the non-matching ack during REQ
    logic [DW-1:0] rdata;     // slave read data, valid the cycle after rresp
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_cfg;   // cycles with cfg_req high
    int            exp_rsp;   // cycle of host_rsp_valid, relative to accept
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.host_req_valid   = 1'b0;
    bus.host_wr_rd_n     = 1'b0;
    bus.host_addr        = '0;
    bus.host_wdata       = '0;
    bus.cbus_mst_waccept = 1'b0;
    bus.cbus_mst_rresp   = 1'b0;
    bus.cbus_mst_rdatap  = 32'h5A5A_5A5A;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {59'd0, bus.host_req_ready, bus.host_rsp_valid, bus.host_rsp_err,
                        bus.cbus_mst_cfg_req, bus.cbus_mst_cmd}, 64'd0);
    chk({tag, "_addr"},  {48'd0, bus.cbus_mst_address}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, bus.cbus_mst_wdata}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, bus.host_rsp_rdata}, 64'd0);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int cyc, cfg_hi, rsp_cyc;
    logic rd_next, hold_ok, rsp_err_v;
    logic [DW-1:0] rsp_data;
    chk("ready_before_accept", {63'd0, bus.host_req_ready}, 64'd1);
    bus.host_req_valid = 1'b1;
    bus.host_wr_rd_n   = v.wr;
    bus.host_addr      = v.addr;
    bus.host_wdata     = v.wdata;
    step();
    idle_inputs();
    chk("setup_cfg_req_low", {63'd0, bus.cbus_mst_cfg_req}, 64'd0);
    if (v.early) begin
      bus.cbus_mst_waccept = 1'b1;
      bus.cbus_mst_rresp   = 1'b1;
    end
    cyc = 1; cfg_hi = 0; rsp_cyc = -1; hold_ok = 1'b1; rd_next = 1'b0;
    rsp_data = '0; rsp_err_v = 1'b0;
    while (rsp_cyc < 0 && cyc < 300) begin
      step();
      cyc++;
      bus.cbus_mst_waccept = 1'b0;
      bus.cbus_mst_rresp   = 1'b0;
      bus.cbus_mst_rdatap  = rd_next ? v.rdata : 32'h5A5A_5A5A;
      rd_next = 1'b0;
      if (bus.cbus_mst_cfg_req) cfg_hi++;
      if (bus.cbus_mst_address !== v.addr || bus.cbus_mst_cmd !== v.wr ||
          bus.cbus_mst_wdata !== v.wdata) hold_ok = 1'b0;
      if (bus.host_rsp_valid) begin
        rsp_cyc   = cyc;
        rsp_data  = bus.host_rsp_rdata;
        rsp_err_v = bus.host_rsp_err;
      end
      if (v.ack_dly >= 0 && cyc == 2 + v.ack_dly) begin
        if (v.wr) bus.cbus_mst_waccept = 1'b1;
        else begin
          bus.cbus_mst_rresp = 1'b1;
          rd_next = 1'b1;
        end
      end
      if (v.noise && bus.cbus_mst_cfg_req) begin
        if (v.wr) bus.cbus_mst_rresp = 1'b1;
        else      bus.cbus_mst_waccept = 1'b1;
      end
    end
    chk("rsp_seen", {63'd0, (rsp_cyc >= 0)}, 64'd1);
    $display("txn %0d: wr=%0b addr=%h cfg_cycles=%0d rsp_cycle=%0d rdata=%h err=%0b",
             idx, v.wr, v.addr, cfg_hi, rsp_cyc, rsp_data, rsp_err_v);
    if (rsp_cyc >= 0) begin
      chk("rsp_cycle", 64'(rsp_cyc), 64'(v.exp_rsp));
      chk("cfg_req_cycles", 64'(cfg_hi), 64'(v.exp_cfg));
      chk("cbus_hold", {63'd0, hold_ok}, 64'd1);
      chk("rsp_rdata", {32'd0, rsp_data}, {32'd0, v.exp_rdata});
      chk("rsp_err", {63'd0, rsp_err_v}, {63'd0, v.exp_err});
      step();
      idle_inputs();
      chk("rsp_pulse_width", {63'd0, bus.host_rsp_valid}, 64'd0);
      chk("ready_after_rsp", {63'd0, bus.host_req_ready}, 64'd1);
    end
  endtask

  task automatic back_to_back();
    int cyc, acc2, age, nrsp, low_run, gap;
    logic rd_next, seen_req;
    logic [DW-1:0] rdat2;
    chk("b2b_ready0", {63'd0, bus.host_req_ready}, 64'd1);
    bus.host_req_valid = 1'b1;
    bus.host_wr_rd_n   = 1'b1;
    bus.host_addr      = 16'h3000;
    bus.host_wdata     = 32'h1111_2222;
    step();
    bus.host_wr_rd_n = 1'b0;
    bus.host_addr    = 16'h3004;
    bus.host_wdata   = '0;
    cyc = 1; acc2 = -1; age = 0; nrsp = 0; low_run = 0; gap = -1;
    rd_next = 1'b0; seen_req = 1'b0; rdat2 = '0;
    while (nrsp < 2 && cyc < 100) begin
      bus.cbus_mst_waccept = 1'b0;
      bus.cbus_mst_rresp   = 1'b0;
      bus.cbus_mst_rdatap  = rd_next ? 32'h7777_8888 : 32'h5A5A_5A5A;
      rd_next = 1'b0;
      if (acc2 >= 0) bus.host_req_valid = 1'b0;
      if (bus.host_req_ready && bus.host_req_valid) acc2 = cyc;
      if (bus.cbus_mst_cfg_req) begin
        if (age == 0 && seen_req) gap = low_run;
        age++;
        seen_req = 1'b1;
        low_run  = 0;
        if (age == 2) begin
          if (bus.cbus_mst_cmd) bus.cbus_mst_waccept = 1'b1;
          else begin
            bus.cbus_mst_rresp = 1'b1;
            rd_next = 1'b1;
          end
        end
      end else begin
        age = 0;
        if (seen_req) low_run++;
      end
      if (bus.host_rsp_valid) begin
        nrsp++;
        if (nrsp == 2) rdat2 = bus.host_rsp_rdata;
      end
      step();
      cyc++;
    end
    idle_inputs();
    $display("b2b: second accept at cycle %0d, cfg_req low gap %0d, responses %0d, rdata=%h",
             acc2, gap, nrsp, rdat2);
    chk("b2b_two_responses", 64'(nrsp), 64'd2);
    chk("b2b_second_accept", 64'(acc2), 64'd6);
    chk("b2b_gap_ge2", {63'd0, (gap >= 2)}, 64'd1);
    chk("b2b_gap", 64'(gap), 64'd4);
    chk("b2b_rdata", {32'd0, rdat2}, 64'h7777_8888);
  endtask

  task automatic reset_in_req();
    int nrsp;
    bus.host_req_valid = 1'b1;
    bus.host_wr_rd_n   = 1'b1;
    bus.host_addr      = 16'h4000;
    bus.host_wdata     = 32'hA5A5_0001;
    step();
    idle_inputs();
    step();
    chk("rst_mid_in_req", {63'd0, bus.cbus_mst_cfg_req}, 64'd1);
    step();
    sreset = 1'b1;
    step();
    sreset = 1'b0;
    chk_all_zero("rst_mid");
    step();
    chk("rst_mid_ready_back", {63'd0, bus.host_req_ready}, 64'd1);
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.host_rsp_valid) nrsp++;
      step();
    end
    $display("reset_in_req: responses after reset %0d", nrsp);
    chk("rst_mid_no_rsp", 64'(nrsp), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sreset = 1'b1;
    idle_inputs();

    //       wr    addr       wdata          dly early noise rdata          exp_rdata      err cfg rsp
    vecs.push_back('{1'b1, 16'h2004, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 4, 7});
    vecs.push_back('{1'b0, 16'hE010, 32'h0000_0000, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 4});
    vecs.push_back('{1'b0, 16'h1230, 32'h0F0F_0F0F, 5, 1'b0, 1'b1, 32'h0BAD_BEEF, 32'h0BAD_BEEF, 1'b0, 6, 9});
    vecs.push_back('{1'b1, 16'hFFFC, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 32'h0,         32'h0,         1'b0, 1, 4});
    vecs.push_back('{1'b0, 16'h8000, 32'h0,         1, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 2, 5});
`ifdef CBUS_MST_TIMEOUT_EN
    vecs.push_back('{1'b0, 16'h5550, 32'h0,        -1, 1'b0, 1'b0, 32'h0,         32'hDEAD_C0DE, 1'b1, 4, 6});
    vecs.push_back('{1'b1, 16'h5554, 32'h1357_9BDF,-1, 1'b0, 1'b1, 32'h0,         32'hDEAD_C0DE, 1'b1, 4, 6});
    vecs.push_back('{1'b0, 16'h5558, 32'h0,         3, 1'b0, 1'b0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 4, 7});
`endif

    repeat (3) step();
    chk_all_zero("reset");
    sreset = 1'b0;
    chk("ready_low_first_cycle", {63'd0, bus.host_req_ready}, 64'd0);
    step();
    chk("ready_after_reset", {63'd0, bus.host_req_ready}, 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(i, vecs[i]);
      step();
    end

    back_to_back();
    step();
    reset_in_req();
    run_txn(99, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
